squeeze: RTL



---
 rtl/sponge_pkg.sv | 26 ++
 rtl/squeeze_f.sv | 76 +++++++
 rtl/squeeze.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sponge_pkg.sv
// Shared sponge definitions: default widths, domain-separator layout and squeeze FSM states.
package sponge_pkg;
    localparam int CWIDTH   = 320;
    localparam int RWIDTH   = 192;
    localparam int XWIDTH   = 128;
    localparam int IWIDTH   = 128;
    localparam int DS_WIDTH = 4;

    localparam logic [DS_WIDTH-1:0] DS_ABSORB_MID  = 4'd0;
    localparam logic [1:0]          DS_SQUEEZE_PAD = 2'b00;
    localparam logic [7:0]          F_RC_BASE      = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        EMIT    = 3'd2,
        RESTART = 3'd3,
        RUNF    = 3'd4,
        DONE    = 3'd5
    } sq_state_t;

    // Squeeze ds: domain bits on top, low two bits reserved for the squeeze marker.
    function automatic logic [DS_WIDTH-1:0] squeeze_ds(input logic [1:0] domain);
        return {domain, DS_SQUEEZE_PAD};
    endfunction
endpackage

// File: rtl/squeeze_f.sv
// Iterative F permutation over {c,r,x}: injects i into r and ds into c, then one round per cycle.
// fdone rises max(rounds,1)+1 cycles after the first en cycle and holds until reset.
module squeeze_f #(
    parameter int CWIDTH      = 320,
    parameter int RWIDTH      = 192,
    parameter int XWORDS32    = 4,
    parameter int IWIDTH      = 128,
    parameter int DS_WIDTH    = 4,
    parameter int ROUND_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [IWIDTH-1:0]      i,
    input  logic [DS_WIDTH-1:0]    ds,
    input  logic [ROUND_COUNT-1:0] rounds,
    input  logic [CWIDTH-1:0]      c_in,
    input  logic [RWIDTH-1:0]      r_in,
    input  logic [32*XWORDS32-1:0] x_in,
    output logic [CWIDTH-1:0]      c_out,
    output logic [RWIDTH-1:0]      r_out,
    output logic [32*XWORDS32-1:0] x_out,
    output logic                   fdone
);
    import sponge_pkg::*;

    localparam int XW = 32 * XWORDS32;
    localparam int SW = CWIDTH + RWIDTH + XW;

    logic [SW-1:0]          s_q, s_d, s_rot;
    logic [ROUND_COUNT-1:0] cnt_q, cnt_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [7:0]             rc;

    assign s_rot = {s_q[SW-8:0], s_q[SW-1:SW-7]};
    assign rc    = F_RC_BASE ^ 8'(cnt_q);

    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        if (en && !busy_q && !done_q) begin
            s_d    = {c_in ^ CWIDTH'(ds), r_in ^ RWIDTH'(i), x_in};
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            s_d   = s_rot ^ (s_q >> 3) ^ SW'(rc);
            cnt_d = cnt_q + ROUND_COUNT'(1);
            // rounds==0 still runs a single round
            if ((cnt_q + ROUND_COUNT'(1)) >= rounds) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign c_out = s_q[SW-1 -: CWIDTH];
    assign r_out = s_q[XW +: RWIDTH];
    assign x_out = s_q[XW-1:0];
    assign fdone = done_q;
endmodule

// File: rtl/squeeze.sv
// Sponge squeeze: emits NUMBLOCKS blocks of rReg[OWIDTH-1:0], running F between blocks.
// First out_valid two cycles after en; out_valid/out_block hold until out_ready completes the handshake.
module squeeze #(
    parameter int CWIDTH      = sponge_pkg::CWIDTH,
    parameter int RWIDTH      = sponge_pkg::RWIDTH,
    parameter int XWIDTH      = sponge_pkg::XWIDTH,
    parameter int OWIDTH      = 128,
    parameter int NUMBLOCKS   = 4,
    parameter int ROUND_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [CWIDTH-1:0]      c,
    input  logic [RWIDTH-1:0]      r,
    input  logic [XWIDTH-1:0]      x,
    input  logic [1:0]             domain,
    input  logic [ROUND_COUNT-1:0] rounds,
    output logic [OWIDTH-1:0]      out_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CWIDTH-1:0]      cout,
    output logic [RWIDTH-1:0]      rout,
    output logic [XWIDTH-1:0]      xout,
    output logic                   done
);
    import sponge_pkg::*;

    localparam int KW = $clog2(NUMBLOCKS) + 1;

    sq_state_t              state_q, state_d;
    logic [CWIDTH-1:0]      c_q, c_d, f_c;
    logic [RWIDTH-1:0]      r_q, r_d, f_r;
    logic [XWIDTH-1:0]      x_q, x_d, f_x;
    logic [1:0]             domain_q, domain_d;
    logic [ROUND_COUNT-1:0] rounds_q, rounds_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   f_reset, f_en, fdone;

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        r_d      = r_q;
        x_d      = x_q;
        domain_d = domain_q;
        rounds_d = rounds_q;
        k_d      = k_q;
        f_reset  = 1'b0;
        f_en     = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = LOAD;
            LOAD: begin
                c_d      = c;
                r_d      = r;
                x_d      = x;
                domain_d = domain;
                rounds_d = rounds;
                k_d      = '0;
                state_d  = EMIT;
            end
            EMIT: if (out_ready) begin
                if (k_q == KW'(NUMBLOCKS - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = RESTART;
                end
            end
            // F keeps fdone high from the previous run, so clear it before each new run
            RESTART: begin
                f_reset = 1'b1;
                state_d = RUNF;
            end
            RUNF: begin
                f_en = 1'b1;
                if (fdone) begin
                    c_d     = f_c;
                    r_d     = f_r;
                    x_d     = f_x;
                    state_d = EMIT;
                end
            end
            DONE: if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            c_q      <= '0;
            r_q      <= '0;
            x_q      <= '0;
            domain_q <= '0;
            rounds_q <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            r_q      <= r_d;
            x_q      <= x_d;
            domain_q <= domain_d;
            rounds_q <= rounds_d;
            k_q      <= k_d;
        end
    end

    squeeze_f #(
        .CWIDTH     (CWIDTH),
        .RWIDTH     (RWIDTH),
        .XWORDS32   (XWIDTH / 32),
        .IWIDTH     (IWIDTH),
        .DS_WIDTH   (DS_WIDTH),
        .ROUND_COUNT(ROUND_COUNT)
    ) u_f (
        .clk   (clk),
        .reset (reset | f_reset),
        .en    (f_en),
        .i     ('0),
        .ds    (squeeze_ds(domain_q)),
        .rounds(rounds_q),
        .c_in  (c_q),
        .r_in  (r_q),
        .x_in  (x_q),
        .c_out (f_c),
        .r_out (f_r),
        .x_out (f_x),
        .fdone (fdone)
    );

    assign out_valid = (state_q == EMIT);
    assign out_block = out_valid ? r_q[OWIDTH-1:0] : '0;
    assign done      = (state_q == DONE);
    assign cout      = done ? c_q : '0;
    assign rout      = done ? r_q : '0;
    assign xout      = done ? x_q : '0;
endmodule
